// File: rtl/vfu_cfu_bridge.sv
// Bridge between the VexRiscv CFU port and the vector core instruction/scalar-result port.
// One-entry command slot towards the core, credit-bounded response FIFO towards the CPU.
module vfu_cfu_bridge #(
    parameter int INSN_WIDTH     = 32,
    parameter int VEX_DATA_WIDTH = 32,
    parameter int RSP_DEPTH_BITS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [INSN_WIDTH-1:0]     cmd_payload_instruction,
    input  logic [VEX_DATA_WIDTH-1:0] cmd_payload_inputs_0,
    input  logic [VEX_DATA_WIDTH-1:0] cmd_payload_inputs_1,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [VEX_DATA_WIDTH-1:0] rsp_payload_output,
    output logic [INSN_WIDTH-1:0]     insn_out,
    output logic                      insn_valid_out,
    input  logic                      proc_rdy_in,
    output logic [VEX_DATA_WIDTH-1:0] vexrv_data_out_1,
    output logic [VEX_DATA_WIDTH-1:0] vexrv_data_out_2,
    input  logic [VEX_DATA_WIDTH-1:0] vexrv_data_in,
    input  logic                      vexrv_valid_in,
    output logic                      err_overflow,
    output logic                      err_unexpected
);

    localparam int PW    = RSP_DEPTH_BITS + 1;
    localparam int DEPTH = 1 << RSP_DEPTH_BITS;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_C   = PW'(1);
    localparam logic [PW-1:0] ZERO_C  = PW'(0);

    logic [PW-1:0]             credit_r;
    logic [PW-1:0]             wr_ptr_r;
    logic [PW-1:0]             rd_ptr_r;
    logic [PW-1:0]             count_s;
    logic                      slot_valid_r;
    logic [INSN_WIDTH-1:0]     insn_r;
    logic [VEX_DATA_WIDTH-1:0] data1_r;
    logic [VEX_DATA_WIDTH-1:0] data2_r;
    logic [VEX_DATA_WIDTH-1:0] mem_r [DEPTH];
    logic                      err_overflow_r;
    logic                      err_unexpected_r;

    logic credit_ok_s;
    logic cmd_fire_s;
    logic rsp_fire_s;
    logic empty_s;
    logic full_s;
    logic push_s;

    assign credit_ok_s = (credit_r < DEPTH_C);
    // rst_n gating keeps cmd_ready low during reset even though credit reads zero then.
    assign cmd_ready   = rst_n & credit_ok_s & (~slot_valid_r | proc_rdy_in);
    assign cmd_fire_s  = cmd_valid & cmd_ready;

    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                        (wr_ptr_r[PW-2:0] == rd_ptr_r[PW-2:0]);
    assign count_s    = wr_ptr_r - rd_ptr_r;
    assign rsp_valid  = ~empty_s;
    assign rsp_fire_s = rsp_valid & rsp_ready;
    // A pop frees the head slot in the same cycle, so a push into a full FIFO is legal then.
    assign push_s     = vexrv_valid_in & (~full_s | rsp_fire_s);

    assign rsp_payload_output = mem_r[rd_ptr_r[PW-2:0]];
    assign insn_valid_out     = slot_valid_r;
    assign insn_out           = insn_r;
    assign vexrv_data_out_1   = data1_r;
    assign vexrv_data_out_2   = data2_r;
    assign err_overflow       = err_overflow_r;
    assign err_unexpected     = err_unexpected_r;

    // Credit counter: commands accepted minus responses taken; never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_r <= ZERO_C;
        end else if (cmd_fire_s && !rsp_fire_s) begin
            credit_r <= credit_r + ONE_C;
        end else if (!cmd_fire_s && rsp_fire_s && (credit_r != ZERO_C)) begin
            credit_r <= credit_r - ONE_C;
        end else begin
            credit_r <= credit_r;
        end
    end

    // Command slot: reloads on accept, clears when the core takes it with nothing new behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_r <= 1'b0;
            insn_r       <= '0;
            data1_r      <= '0;
            data2_r      <= '0;
        end else if (cmd_fire_s) begin
            slot_valid_r <= 1'b1;
            insn_r       <= cmd_payload_instruction;
            data1_r      <= cmd_payload_inputs_0;
            data2_r      <= cmd_payload_inputs_1;
        end else if (slot_valid_r && proc_rdy_in) begin
            slot_valid_r <= 1'b0;
        end else begin
            slot_valid_r <= slot_valid_r;
        end
    end

    // Response FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= ZERO_C;
            rd_ptr_r <= ZERO_C;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[PW-2:0]] <= vexrv_data_in;
                wr_ptr_r                <= wr_ptr_r + ONE_C;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rsp_fire_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Sticky protocol-violation flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow_r   <= 1'b0;
            err_unexpected_r <= 1'b0;
        end else begin
            if (vexrv_valid_in && full_s && !rsp_fire_s) begin
                err_overflow_r <= 1'b1;
            end else begin
                err_overflow_r <= err_overflow_r;
            end
            if (vexrv_valid_in && (credit_r == count_s)) begin
                err_unexpected_r <= 1'b1;
            end else begin
                err_unexpected_r <= err_unexpected_r;
            end
        end
    end

endmodule

// File: tb/tb_vfu_cfu_bridge.sv
// Directed bench for vfu_cfu_bridge: single op, stall, backpressure, full push/pop, errors, reset.
module tb_vfu_cfu_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_payload_instruction;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_output;
    logic [31:0] insn_out;
    logic        insn_valid_out;
    logic        proc_rdy_in;
    logic [31:0] vexrv_data_out_1;
    logic [31:0] vexrv_data_out_2;
    logic [31:0] vexrv_data_in;
    logic        vexrv_valid_in;
    logic        err_overflow;
    logic        err_unexpected;

    int n_cmp = 0;
    int n_err = 0;

    vfu_cfu_bridge #(
        .INSN_WIDTH(32), .VEX_DATA_WIDTH(32), .RSP_DEPTH_BITS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_instruction(cmd_payload_instruction),
        .cmd_payload_inputs_0(cmd_payload_inputs_0),
        .cmd_payload_inputs_1(cmd_payload_inputs_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_payload_output(rsp_payload_output),
        .insn_out(insn_out), .insn_valid_out(insn_valid_out),
        .proc_rdy_in(proc_rdy_in),
        .vexrv_data_out_1(vexrv_data_out_1), .vexrv_data_out_2(vexrv_data_out_2),
        .vexrv_data_in(vexrv_data_in), .vexrv_valid_in(vexrv_valid_in),
        .err_overflow(err_overflow), .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmds(input int n, input logic [31:0] base);
        cmd_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            cmd_payload_instruction = base + 32'(i);
            settle();
            check("fill_cmd_ready", {31'd0, cmd_ready}, 32'd1);
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic push_rsps(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            vexrv_valid_in = 1'b1;
            vexrv_data_in  = base + 32'(i);
            tick();
        end
        vexrv_valid_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b1; rsp_ready = 1'b0; proc_rdy_in = 1'b1;
        cmd_payload_instruction = 32'd0; cmd_payload_inputs_0 = 32'd0; cmd_payload_inputs_1 = 32'd0;
        vexrv_data_in = 32'd0; vexrv_valid_in = 1'b0;
        settle();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_insn_valid", {31'd0, insn_valid_out}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_insn_out", insn_out, 32'd0);
        check("rst_err", {30'd0, err_overflow, err_unexpected}, 32'd0);
        tick(); tick();
        cmd_valid = 1'b0;
        rst_n = 1'b1;

        // Single op
        cmd_valid = 1'b1; cmd_payload_instruction = 32'h0000_5057;
        cmd_payload_inputs_0 = 32'h11; cmd_payload_inputs_1 = 32'h22; rsp_ready = 1'b1;
        settle();
        check("single_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        settle();
        check("single_insn_valid", {31'd0, insn_valid_out}, 32'd1);
        check("single_insn", insn_out, 32'h0000_5057);
        check("single_d1", vexrv_data_out_1, 32'h11);
        check("single_d2", vexrv_data_out_2, 32'h22);
        tick();
        check("single_slot_drained", {31'd0, insn_valid_out}, 32'd0);
        tick(); tick();
        vexrv_valid_in = 1'b1; vexrv_data_in = 32'hCAFE;
        settle();
        check("single_no_bypass", {31'd0, rsp_valid}, 32'd0);
        tick();
        vexrv_valid_in = 1'b0;
        check("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("single_rsp_data", rsp_payload_output, 32'hCAFE);
        tick();
        check("single_rsp_popped", {31'd0, rsp_valid}, 32'd0);
        check("single_credit", 32'(dut.credit_r), 32'd0);
        check("single_err", {30'd0, err_overflow, err_unexpected}, 32'd0);

        // Core stall
        proc_rdy_in = 1'b0; cmd_valid = 1'b1;
        cmd_payload_instruction = 32'h1111_0001; cmd_payload_inputs_0 = 32'hA; cmd_payload_inputs_1 = 32'hB;
        tick();
        cmd_payload_instruction = 32'h2222_0002; cmd_payload_inputs_0 = 32'hC; cmd_payload_inputs_1 = 32'hD;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("stall_insn", insn_out, 32'h1111_0001);
            check("stall_d1", vexrv_data_out_1, 32'hA);
            check("stall_d2", vexrv_data_out_2, 32'hB);
            tick();
        end
        proc_rdy_in = 1'b1;
        settle();
        check("stall_release_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("stall_reload_valid", {31'd0, insn_valid_out}, 32'd1);
        check("stall_reload_insn", insn_out, 32'h2222_0002);
        check("stall_reload_d1", vexrv_data_out_1, 32'hC);
        tick();
        check("stall_drained", {31'd0, insn_valid_out}, 32'd0);
        rsp_ready = 1'b0;
        push_rsps(2, 32'h51);
        check("stall_rsp0", rsp_payload_output, 32'h51);
        rsp_ready = 1'b1;
        tick();
        check("stall_rsp1", rsp_payload_output, 32'h52);
        tick();
        check("stall_empty", {31'd0, rsp_valid}, 32'd0);
        check("stall_credit", 32'(dut.credit_r), 32'd0);

        // Backpressure: six attempts, only four accepted
        rsp_ready = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_payload_instruction = 32'h100 + 32'(i);
            settle();
            check("bp_cmd_ready", {31'd0, cmd_ready}, (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        cmd_valid = 1'b0;
        push_rsps(4, 32'hA0);
        check("bp_count", 32'(dut.count_s), 32'd4);
        check("bp_credit_block", {31'd0, cmd_ready}, 32'd0);
        check("bp_err", {30'd0, err_overflow, err_unexpected}, 32'd0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_pop_data", rsp_payload_output, 32'hA0 + 32'(k));
            tick();
            check("bp_ready_back", {31'd0, cmd_ready}, 32'd1);
        end
        check("bp_empty", {31'd0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;

        // Unexpected result with zero credit
        vexrv_valid_in = 1'b1; vexrv_data_in = 32'hEE;
        tick();
        vexrv_valid_in = 1'b0;
        check("unexp_flag", {31'd0, err_unexpected}, 32'd1);
        check("unexp_ovf_clear", {31'd0, err_overflow}, 32'd0);
        check("unexp_data", rsp_payload_output, 32'hEE);
        rsp_ready = 1'b1;
        tick();
        check("unexp_popped", {31'd0, rsp_valid}, 32'd0);
        check("unexp_credit", 32'(dut.credit_r), 32'd0);
        rsp_ready = 1'b0;

        // Simultaneous push/pop at full
        send_cmds(4, 32'h200);
        push_rsps(4, 32'hB0);
        check("pp_full_count", 32'(dut.count_s), 32'd4);
        vexrv_valid_in = 1'b1; vexrv_data_in = 32'hBE; rsp_ready = 1'b1;
        tick();
        vexrv_valid_in = 1'b0; rsp_ready = 1'b0;
        check("pp_count", 32'(dut.count_s), 32'd4);
        check("pp_no_overflow", {31'd0, err_overflow}, 32'd0);
        check("pp_head", rsp_payload_output, 32'hB1);
        rsp_ready = 1'b1;
        check("pp_drain0", rsp_payload_output, 32'hB1); tick();
        check("pp_drain1", rsp_payload_output, 32'hB2); tick();
        check("pp_drain2", rsp_payload_output, 32'hB3); tick();
        check("pp_drain3", rsp_payload_output, 32'hBE); tick();
        check("pp_empty", {31'd0, rsp_valid}, 32'd0);
        check("pp_credit", 32'(dut.credit_r), 32'd0);
        rsp_ready = 1'b0;

        // Overflow: push into full FIFO without a pop
        send_cmds(4, 32'h300);
        push_rsps(4, 32'hC0);
        vexrv_valid_in = 1'b1; vexrv_data_in = 32'hDD;
        tick();
        vexrv_valid_in = 1'b0;
        check("ovf_flag", {31'd0, err_overflow}, 32'd1);
        check("ovf_count", 32'(dut.count_s), 32'd4);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("ovf_drain", rsp_payload_output, 32'hC0 + 32'(k));
            tick();
        end
        check("ovf_dropped", {31'd0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;

        // Async reset mid-burst
        proc_rdy_in = 1'b0; cmd_valid = 1'b1; cmd_payload_instruction = 32'h77;
        vexrv_valid_in = 1'b1; vexrv_data_in = 32'h99;
        tick();
        vexrv_valid_in = 1'b0; cmd_valid = 1'b0;
        check("ar_pre_insn_valid", {31'd0, insn_valid_out}, 32'd1);
        check("ar_pre_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        settle();
        check("ar_insn_valid", {31'd0, insn_valid_out}, 32'd0);
        check("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("ar_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("ar_err", {30'd0, err_overflow, err_unexpected}, 32'd0);
        tick();
        rst_n = 1'b1;
        settle();
        check("ar_credit", 32'(dut.credit_r), 32'd0);
        check("ar_count", 32'(dut.count_s), 32'd0);
        check("ar_insn_out", insn_out, 32'd0);
        check("ar_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
